vga_timing_counter: RTL and testbench

- Upstream timing source for the VGA output path. Free-running horizontal and vertical counters drive the HSync generator (via cntHorizontal) and the VSync generator (via cntVertical).
- Also supplies the active-video flag, pixel coordinates and line/frame strobes to the pixel pipeline.
- Runs on the 50 MHz system clock. Horizontal count is in clock units, 1600 clocks per line (2 clocks per 25 MHz pixel); 525 lines per frame.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/vga_timing_counter_if.sv | 27 ++
 rtl/vga_timing_counter_mod_counter.sv | 38 +++
 rtl/vga_timing_counter.sv | 56 +++++
 tb/tb_vga_timing_counter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants for counters and sync generators
package vga_timing_pkg;

   localparam int H_TOTAL     = 1600;
   localparam int V_TOTAL     = 525;
   localparam int H_ACT_START = 97;
   localparam int H_ACT_END   = 1376;
   localparam int V_ACT_START = 0;
   localparam int V_ACT_END   = 479;
   localparam int HSYNC_START = 1;
   localparam int HSYNC_END   = 1408;
   localparam int VSYNC_START = 490;
   localparam int VSYNC_END   = 491;

   localparam int H_W   = 11;
   localparam int V_W   = 10;
   localparam int PIX_W = 10;

endpackage

// File: rtl/vga_timing_counter_if.sv
// rtl/vga_timing_counter_if.sv - enable input and timing outputs of the VGA counter
interface vga_timing_counter_if;
   import vga_timing_pkg::*;

   logic             enable;
   logic [H_W-1:0]   cntHorizontal;
   logic [V_W-1:0]   cntVertical;
   logic             videoOn;
   logic [PIX_W-1:0] pixelX;
   logic [PIX_W-1:0] pixelY;
   logic             pixelTick;
   logic             lineEnd;
   logic             frameEnd;

   modport master (
      input  enable,
      output cntHorizontal, cntVertical, videoOn, pixelX, pixelY,
             pixelTick, lineEnd, frameEnd
   );

   modport slave (
      output enable,
      input  cntHorizontal, cntVertical, videoOn, pixelX, pixelY,
             pixelTick, lineEnd, frameEnd
   );

endinterface

// File: rtl/vga_timing_counter_mod_counter.sv
// rtl/vga_timing_counter_mod_counter.sv - modulo-MAX counter with enable-qualified wrap strobe
module mod_counter #(
   parameter int MAX   = 1600,
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             at_top;

   // >= rather than == so a corrupted count recovers to 0 instead of running off
   assign at_top = (count_q >= WIDTH'(MAX - 1));

   always_comb begin
      count_d = count_q;
      if (en) begin
         count_d = at_top ? '0 : count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign wrap  = en & at_top;

endmodule

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - free-running line/frame counters with active-window decode
module vga_timing_counter
   import vga_timing_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   vga_timing_counter_if.master  bus
);

   logic [H_W-1:0] cnt_h;
   logic [V_W-1:0] cnt_v;
   logic           h_wrap;
   logic           v_wrap;
   logic [H_W-1:0] h_off;
   logic [V_W-1:0] v_off;
   logic           h_act;
   logic           v_act;
   logic           video_on;

   mod_counter #(.MAX(H_TOTAL), .WIDTH(H_W)) u_horz (
      .clk   (clk),
      .reset (reset),
      .en    (bus.enable),
      .count (cnt_h),
      .wrap  (h_wrap)
   );

   mod_counter #(.MAX(V_TOTAL), .WIDTH(V_W)) u_vert (
      .clk   (clk),
      .reset (reset),
      .en    (h_wrap),
      .count (cnt_v),
      .wrap  (v_wrap)
   );

   // Offset-from-start compares cover both window bounds with one unsigned test
   always_comb begin
      h_off    = cnt_h - H_W'(H_ACT_START);
      v_off    = cnt_v - V_W'(V_ACT_START);
      h_act    = (h_off <= H_W'(H_ACT_END - H_ACT_START));
      v_act    = (v_off <= V_W'(V_ACT_END - V_ACT_START));
      video_on = h_act & v_act;
   end

   always_comb begin
      bus.cntHorizontal = cnt_h;
      bus.cntVertical   = cnt_v;
      bus.videoOn       = video_on;
      bus.pixelX        = video_on ? h_off[H_W-1:1] : '0;
      bus.pixelY        = video_on ? v_off : '0;
      bus.pixelTick     = video_on & ~h_off[0];
      bus.lineEnd       = h_wrap;
      bus.frameEnd      = v_wrap;
   end

endmodule

// File: tb/tb_vga_timing_counter.sv
// tb/tb_vga_timing_counter.sv - scoreboard bench for vga_timing_counter against a frame-index model
module tb_vga_timing_counter;

   typedef struct {
      int h;
      int v;
      int von;
      int px;
      int py;
      int tick;
      int le;
      int fe;
   } exp_t;

   logic clk;
   logic reset;

   vga_timing_counter_if bus ();

   vga_timing_counter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   m_h    = 0;
   int   m_v    = 0;
   int   cyc    = 0;
   bit   sim_done = 0;

   function automatic exp_t expect_of(int h, int v, int en);
      exp_t e;
      e.h    = h;
      e.v    = v;
      e.von  = (h >= 97 && h <= 1376 && v >= 0 && v <= 479) ? 1 : 0;
      e.px   = e.von ? (h - 97) / 2 : 0;
      e.py   = e.von ? v : 0;
      e.tick = (e.von && ((h - 97) % 2 == 0)) ? 1 : 0;
      e.le   = (en && h == 1599) ? 1 : 0;
      e.fe   = (e.le && v == 524) ? 1 : 0;
      return e;
   endfunction

   task automatic step(input logic r, input logic en);
      int idx;
      @(negedge clk);
      reset      = r;
      bus.enable = en;
      exp_q.push_back(expect_of(m_h, m_v, int'(en)));
      if (r) begin
         m_h = 0;
         m_v = 0;
      end else if (en) begin
         idx = (m_v * 1600 + m_h + 1) % (1600 * 525);
         m_h = idx % 1600;
         m_v = idx / 1600;
      end
      cyc++;
   endtask

   always begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
         exp_t e;
         exp_t a;
         e      = exp_q.pop_front();
         a.h    = int'(bus.cntHorizontal);
         a.v    = int'(bus.cntVertical);
         a.von  = int'(bus.videoOn);
         a.px   = int'(bus.pixelX);
         a.py   = int'(bus.pixelY);
         a.tick = int'(bus.pixelTick);
         a.le   = int'(bus.lineEnd);
         a.fe   = int'(bus.frameEnd);
         n_cmp++;
         if (a != e) begin
            n_fail++;
            $display("FAIL timing t=%0t got h=%0d v=%0d von=%0d px=%0d py=%0d tick=%0d le=%0d fe=%0d expected h=%0d v=%0d von=%0d px=%0d py=%0d tick=%0d le=%0d fe=%0d",
                     $time, a.h, a.v, a.von, a.px, a.py, a.tick, a.le, a.fe,
                     e.h, e.v, e.von, e.px, e.py, e.tick, e.le, e.fe);
         end
      end
   end

   initial begin
      int guard;
      reset      = 1'b1;
      bus.enable = 1'b1;
      @(posedge clk);

      // reset held with enable high, then release and run two full lines
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 3300; i++) step(1'b0, 1'b1);

      // randomized enable with rare resets
      for (int i = 0; i < 20000; i++) begin
         step(($urandom_range(0, 3999) == 0), ($urandom_range(0, 9) != 0));
      end

      // freeze exactly at the last clock of a line
      guard = 0;
      while (m_h != 1599 && guard < 4000) begin
         step(1'b0, 1'b1);
         guard++;
      end
      if (m_h != 1599) begin
         n_fail++;
         $display("FAIL freeze_setup model_h=%0d required=1599", m_h);
      end
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);

      // mid-line reset at count 800
      guard = 0;
      while (m_h != 800 && guard < 4000) begin
         step(1'b0, 1'b1);
         guard++;
      end
      step(1'b1, 1'b1);
      for (int i = 0; i < 1700; i++) step(1'b0, 1'b1);

      // reset while frozen must still clear counters
      for (int i = 0; i < 300; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 200; i++) step(1'b0, 1'b1);

      @(negedge clk);
      @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain left=%0d required=0", exp_q.size());
      end
      if (n_cmp < 12) begin
         n_fail++;
         $display("FAIL compare_count got=%0d required>=12", n_cmp);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      sim_done = 1;
      $finish;
   end

   initial begin
      #2000000;
      if (!sim_done) begin
         $display("FAIL timeout cycles=%0d", cyc);
         $fatal(1, "timeout");
      end
   end

endmodule
